// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial add/subtract, one full-adder slice over WIDTH clocks; SERIAL_ADD_SUB_ZERO_FLAG_EN adds a zero-result flag.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, result_q, result_d, shifted;
  logic [WIDTH-2:0] acc_q, acc_d;
  logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d, sum, cnext;
  logic sticky_q, sticky_d, zero_q, zero_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      sticky_q <= sticky_d;
      zero_q   <= zero_d;
    end
  end
  assign sum     = sa_q[0] ^ sb_q[0] ^ c_q;
  assign cnext   = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
  assign shifted = {sum, acc_q};
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    result_d = result_q;
    c_d      = c_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    sticky_d = sticky_q;
    zero_d   = zero_q;
    if (state_q == IDLE) begin
      if (start) begin
        // subtract as a + ~b + 1: the +1 rides in on the carry FF
        sa_d     = a;
        sb_d     = b ^ {WIDTH{mode}};
        c_d      = mode;
        cnt_d    = '0;
        sticky_d = 1'b0;
        state_d  = RUN;
      end
    end else begin
      sa_d     = sa_q >> 1;
      sb_d     = sb_q >> 1;
      acc_d    = shifted[WIDTH-1:1];
      c_d      = cnext;
      cnt_d    = cnt_q + 1'b1;
      sticky_d = sticky_q | sum;
      if (cnt_q == LAST) begin
        // c_q here is the carry into the MSB slice
        result_d = shifted;
        cout_d   = cnext;
        ovf_d    = c_q ^ cnext;
        zero_d   = ~(sticky_q | sum);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
    end
  end
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
  assign zero     = zero_q;
`else
  logic unused_zero;
  assign unused_zero = zero_q;
`endif
endmodule
